// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: default widths,
// divide FSM states and the iteration-counter width helper.
package muldiv_pkg;

    localparam int MD_W          = 32;
    localparam int MD_DIV_CYCLES = 32;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MD_CNT_W = cnt_width(MD_DIV_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider core: one quotient bit per step, MSB first.
// Operands are magnitudes; sign handling lives in the caller.
module div_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         start_i,
    input  logic         step_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o
);

    logic [W-1:0] rem_q;
    logic [W-1:0] quo_q;
    logic [W-1:0] dvs_q;
    logic [W:0]   shifted;
    logic [W:0]   diff;

    // Partial remainder stays below the divisor, so bit W of diff is a clean borrow.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            if (!diff[W]) begin
                rem_q <= diff[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
                rem_q <= shifted[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: single-cycle MULT/MULTU/MTHI/MTLO and a
// multi-cycle DIV/DIVU sequenced by a small IDLE/DIV/DONE FSM.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no divide in flight; accepts ops from decode
//   DIV     | iterating, one quotient bit per cycle for DIV_CYCLES cycles
//   DONE    | write fixed-up quotient/remainder to LO/HI, back to IDLE
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int W          = MD_W,
    parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic         is_mult,
    input  logic         is_multu,
    input  logic         is_div,
    input  logic         is_divu,
    input  logic         lo_wen,
    input  logic         hi_wen,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic [W-1:0] product
);

    localparam int            CW       = cnt_width(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;

    logic [5:0]    sel;
    logic          one_hot;
    logic          accept;
    logic          div_start;
    logic          ext_a, ext_b;
    logic [2*W-1:0] mul_full;
    logic [W-1:0]  a_mag, b_mag;
    logic [W-1:0]  quo_raw, rem_raw;
    logic [W-1:0]  quo_fix, rem_fix;
    logic          neg_quo_q, neg_rem_q, div0_q;

    assign sel       = {is_mult, is_multu, is_div, is_divu, lo_wen, hi_wen};
    assign one_hot   = (sel != '0) && ((sel & (sel - 6'd1)) == '0);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = en && !busy && !flush && one_hot;
    assign div_start = accept && (is_div || is_divu);

    // Low word of the product does not depend on the extension, so MUL can use it directly.
    assign ext_a    = is_mult & a[W-1];
    assign ext_b    = is_mult & b[W-1];
    assign mul_full = {{W{ext_a}}, a} * {{W{ext_b}}, b};
    assign product  = mul_full[W-1:0];

    assign a_mag = (is_div && a[W-1]) ? -a : a;
    assign b_mag = (is_div && b[W-1]) ? -b : b;

    always_ff @(posedge clk) begin
        if (div_start) begin
            neg_quo_q <= is_div & (a[W-1] ^ b[W-1]);
            neg_rem_q <= is_div & a[W-1];
            div0_q    <= (b == '0);
        end
    end

    div_iter #(.W(W)) u_div_iter (
        .clk         (clk),
        .start_i     (div_start),
        .step_i      (state_q == ST_DIV),
        .dividend_i  (a_mag),
        .divisor_i   (b_mag),
        .quotient_o  (quo_raw),
        .remainder_o (rem_raw)
    );

    assign quo_fix = neg_quo_q ? -quo_raw : quo_raw;
    assign rem_fix = neg_rem_q ? -rem_raw : rem_raw;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (div_start) state_d = ST_DIV;
            end
            ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A flush landing in DONE cancels the write; divide by zero never writes.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (accept) begin
            if (is_mult || is_multu) {hi_d, lo_d} = mul_full;
            if (hi_wen)              hi_d = a;
            if (lo_wen)              lo_d = a;
        end
        if (state_q == ST_DONE && !flush && !div0_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: multiply, HI/LO moves, signed/unsigned
// divide with latency, divide by zero, flush and mid-divide reset.
module tb_hilo_muldiv;

    localparam int DIV_CYCLES = 32;
    localparam int LATENCY    = DIV_CYCLES + 2;

    localparam logic [5:0] OP_MULT  = 6'b100000;
    localparam logic [5:0] OP_MULTU = 6'b010000;
    localparam logic [5:0] OP_DIV   = 6'b001000;
    localparam logic [5:0] OP_DIVU  = 6'b000100;
    localparam logic [5:0] OP_MTLO  = 6'b000010;
    localparam logic [5:0] OP_MTHI  = 6'b000001;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en, is_mult, is_multu, is_div, is_divu, lo_wen, hi_wen, flush;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo, product;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    hilo_muldiv #(.W(32), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .en       (en),
        .is_mult  (is_mult),
        .is_multu (is_multu),
        .is_div   (is_div),
        .is_divu  (is_divu),
        .lo_wen   (lo_wen),
        .hi_wen   (hi_wen),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .product  (product)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic e, input logic fl);
        {is_mult, is_multu, is_div, is_divu, lo_wen, hi_wen} = sel;
        a     = av;
        b     = bv;
        en    = e;
        flush = fl;
    endtask

    // Present an op for one cycle; returns on the negedge after the issue edge.
    task automatic issue(input logic [5:0] sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic fl);
        drive(sel, av, bv, 1'b1, fl);
        @(negedge clk);
        drive(6'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic run_div(input string tag, input logic [5:0] sel, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int c;
        issue(sel, av, bv, 1'b0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        wait_idle(c);
        check({tag, "_latency"}, c + 1, LATENCY);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
    endtask

    initial begin
        resetn = 1'b0;
        drive(6'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // product is combinational; op with en=0 must be ignored
        drive(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        #1 check("prod_neg", product, 32'hFFFF_FFFA);
        a = 32'd7; b = 32'd6;
        #1 check("prod_small", product, 32'h0000_002A);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        #1 check("prod_m1", product, 32'h0000_0001);
        @(negedge clk);
        check("noen_hi", hi, 32'h0);
        check("noen_lo", lo, 32'h0);
        drive(6'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        check("mult_busy", {31'b0, busy}, 32'd0);
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        issue(OP_MTHI, 32'hAAAA_0000, 32'h0, 1'b0);
        check("mthi_hi", hi, 32'hAAAA_0000);
        check("mthi_lo", lo, 32'hFFFF_FFFA);
        issue(OP_MTLO, 32'h0000_5555, 32'h0, 1'b0);
        check("mtlo_hi", hi, 32'hAAAA_0000);
        check("mtlo_lo", lo, 32'h0000_5555);

        issue(OP_MULT | OP_DIVU, 32'd9, 32'd3, 1'b0);
        check("multisel_hi", hi, 32'hAAAA_0000);
        check("multisel_lo", lo, 32'h0000_5555);
        check("multisel_busy", {31'b0, busy}, 32'd0);

        issue(OP_MTHI, 32'h0000_0BAD, 32'h0, 1'b1);
        check("idleflush_hi", hi, 32'hAAAA_0000);
        check("idleflush_busy", {31'b0, busy}, 32'd0);

        run_div("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("divu_100_7", OP_DIVU, 32'd100,       32'd7,        32'd14,        32'd2);
        run_div("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        run_div("div_7_m2",   OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'h0);
        run_div("div_m8_m3",  OP_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,        32'hFFFF_FFFE);
        run_div("divu_5_0",   OP_DIVU, 32'd5,         32'd0,        32'd2,         32'hFFFF_FFFE);

        // flush during DIV, with an MTLO attempted while busy
        issue(OP_MTHI, 32'h1111_1111, 32'h0, 1'b0);
        issue(OP_MTLO, 32'h2222_2222, 32'h0, 1'b0);
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b0);
        issue(OP_MTLO, 32'h0000_DEAD, 32'h0, 1'b0);
        check("busy_mtlo_lo", lo, 32'h2222_2222);
        repeat (7) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flushdiv_busy", {31'b0, busy}, 32'd0);
        check("flushdiv_hi", hi, 32'h1111_1111);
        check("flushdiv_lo", lo, 32'h2222_2222);
        repeat (40) @(negedge clk);
        check("flushdiv_late_hi", hi, 32'h1111_1111);
        check("flushdiv_late_lo", lo, 32'h2222_2222);

        // flush landing in DONE beats the write
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b0);
        repeat (DIV_CYCLES) @(negedge clk);
        check("done_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flushdone_busy", {31'b0, busy}, 32'd0);
        check("flushdone_hi", hi, 32'h1111_1111);
        check("flushdone_lo", lo, 32'h2222_2222);
        run_div("divu_1000_3", OP_DIVU, 32'd1000, 32'd3, 32'd333, 32'd1);

        // asynchronous reset in the middle of a divide
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (19) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("postrst_hi", hi, 32'h0);
        check("postrst_lo", lo, 32'h0);
        check("postrst_busy", {31'b0, busy}, 32'd0);
        issue(OP_MTHI, 32'h0000_1234, 32'h0, 1'b0);
        check("postrst_mthi_hi", hi, 32'h0000_1234);
        check("postrst_mthi_lo", lo, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
